// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF/MEM requester handshakes and the MainMemory port around mem_port_arbiter.
// slave = arbiter side, master = pipeline stages plus the memory model.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic             i_req;
  logic [AW-1:0]    i_addr;
  logic             d_req;
  logic             d_we;
  logic [AW-1:0]    d_addr;
  logic [DW-1:0]    d_wdata;
  logic             i_ack;
  logic             d_ack;
  logic [DW-1:0]    rdata;
  logic             stop_f;
  logic             stop_m;
  logic             mem_en;
  logic [AW-1:0]    mem_addr;
  logic [AW+DW:0]   mem_serial;
  logic [DW-1:0]    mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, d_ack, rdata, stop_f, stop_m, mem_en, mem_addr, mem_serial
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, d_ack, rdata, stop_f, stop_m, mem_en, mem_addr, mem_serial
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares MainMemory between fetch (I) and mem-stage (D); ARB_ROUND_ROBIN_EN swaps D-first priority for alternation.
// Latency: grant edge k -> mem_en cycles k+1..k+MEM_LAT, ack in cycle k+MEM_LAT+1; grants >= MEM_LAT+2 apart.
// Backpressure: requests hold until ack; stop_f/stop_m stall the pipeline meanwhile.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       own_d;
  logic       pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;
  // Alternate only on contention; a lone request always wins.
  assign pick_d = bus.d_req & (~bus.i_req | ~last_d);
`else
  // MEM-stage instruction is older, so it goes first.
  assign pick_d = bus.d_req;
`endif

  assign bus.stop_f = bus.i_req & ~bus.i_ack;
  assign bus.stop_m = bus.d_req & ~bus.d_ack;

  // mem_serial doubles as the latched {we, addr, wdata} of the granted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      own_d          <= 1'b0;
      bus.i_ack      <= 1'b0;
      bus.d_ack      <= 1'b0;
      bus.rdata      <= '0;
      bus.mem_en     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_serial <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.i_ack <= 1'b0;
          bus.d_ack <= 1'b0;
          if (bus.i_req | bus.d_req) begin
            own_d      <= pick_d;
            cnt        <= CNT_INIT;
            state      <= BUSY;
            bus.mem_en <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_d     <= pick_d;
`endif
            if (pick_d) begin
              bus.mem_addr   <= bus.d_addr;
              bus.mem_serial <= {bus.d_we, bus.d_addr, bus.d_wdata};
            end else begin
              bus.mem_addr   <= bus.i_addr;
              bus.mem_serial <= {1'b0, bus.i_addr, {DW{1'b0}}};
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state      <= DONE;
            bus.mem_en <= 1'b0;
            if (own_d) bus.d_ack <= 1'b1;
            else       bus.i_ack <= 1'b1;
            if (!bus.mem_serial[AW+DW]) bus.rdata <= bus.mem_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          bus.i_ack <= 1'b0;
          bus.d_ack <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts grants and timing,
// a negedge monitor checks the memory port, acks, stalls and read data.
module tb_mem_port_arbiter;
  localparam int L  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] RKEY = 32'hDEADBEAF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();
  mem_port_arbiter #(.MEM_LAT(L), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: read data is a fixed function of the presented address.
  assign bus.mem_rdata = bus.mem_en ? (bus.mem_addr ^ RKEY) : '0;

  typedef struct {
    bit            d;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd;
    int            g;
  } txn_t;

  typedef enum {R_IDLE, R_HELD, R_DROP} rq_t;

  txn_t          q[$];
  int            checks = 0;
  int            failures = 0;
  int            m = 1;
  int            next_free = 0;
  bit            last_d = 1'b0;
  bit            mon_en = 1'b0;
  logic [DW-1:0] rdata_m = '0;
  rq_t           ist = R_IDLE;
  rq_t           dst = R_IDLE;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, m, act, exp);
    end
  endtask

  function automatic bit in_busy(input bit d);
    return q.size() > 0 && q[0].d == d && m > q[0].g && m <= q[0].g + L;
  endfunction

  task automatic start_i(input logic [AW-1:0] a);
    if (ist == R_IDLE) begin
      bus.i_req = 1'b1; bus.i_addr = a; ist = R_HELD;
    end
  endtask

  task automatic start_d(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] w);
    if (dst == R_IDLE) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = w; dst = R_HELD;
    end
  endtask

  // Reference: decides what happens at the coming edge m from the inputs now driven.
  task automatic model();
    txn_t t;
    if (reset) begin
      q.delete(); rdata_m = '0; next_free = m + 1; last_d = 1'b0;
      return;
    end
    if (m >= next_free && (bus.i_req || bus.d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
      t.d = bus.d_req && !(bus.i_req && last_d);
`else
      t.d = bus.d_req;
`endif
      last_d  = t.d;
      t.we    = t.d ? bus.d_we : 1'b0;
      t.addr  = t.d ? bus.d_addr : bus.i_addr;
      t.wdata = t.d ? bus.d_wdata : '0;
      if (!t.we) rdata_m = t.addr ^ RKEY;
      t.rd = rdata_m;
      t.g  = m;
      q.push_back(t);
      next_free = m + L + 2;
    end
  endtask

  task automatic tick(input bit rnd);
    model();
    @(posedge clk);
    #1;
    m++;
    if (bus.i_ack) begin ist = R_IDLE; bus.i_req = 1'b0; end
    if (bus.d_ack) begin dst = R_IDLE; bus.d_req = 1'b0; end
    if (rnd) begin
      if (ist == R_IDLE && $urandom_range(2) == 0) start_i($urandom);
      if (dst == R_IDLE && $urandom_range(2) == 0) start_d(1'($urandom_range(1)), $urandom, $urandom);
      if (in_busy(1'b0)) begin
        if ($urandom_range(1) == 1) bus.i_addr = $urandom;
        if (ist == R_HELD && $urandom_range(3) == 0) begin bus.i_req = 1'b0; ist = R_DROP; end
      end
      if (in_busy(1'b1)) begin
        if ($urandom_range(1) == 1) begin
          bus.d_addr = $urandom; bus.d_wdata = $urandom; bus.d_we = 1'($urandom_range(1));
        end
        if (dst == R_HELD && $urandom_range(3) == 0) begin bus.d_req = 1'b0; dst = R_DROP; end
      end
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((ist != R_IDLE || dst != R_IDLE) && n < 60) begin
      tick(1'b0);
      n++;
    end
    chk({nm, "_timeout"}, 128'(n < 60), 128'(1));
    repeat (2) tick(1'b0);
  endtask

  always @(negedge clk) begin : mon
    bit   exp_en, exp_ia, exp_da;
    txn_t t;
    if (mon_en && !reset) begin
      exp_en = 1'b0; exp_ia = 1'b0; exp_da = 1'b0;
      if (q.size() > 0) begin
        if (m > q[0].g && m <= q[0].g + L) exp_en = 1'b1;
        if (m == q[0].g + L + 1) begin exp_ia = !q[0].d; exp_da = q[0].d; end
      end
      chk("mem_en", bus.mem_en, exp_en);
      if (exp_en) begin
        chk("mem_addr", bus.mem_addr, q[0].addr);
        chk("mem_serial", bus.mem_serial, {q[0].we, q[0].addr, q[0].wdata});
      end
      chk("i_ack", bus.i_ack, exp_ia);
      chk("d_ack", bus.d_ack, exp_da);
      chk("stop_f", bus.stop_f, bus.i_req & ~exp_ia);
      chk("stop_m", bus.stop_m, bus.d_req & ~exp_da);
      if (q.size() > 0 && m == q[0].g + L + 1) begin
        t = q.pop_front();
        chk("rdata", bus.rdata, t.rd);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) tick(1'b0);
    reset = 1'b0;
    chk("rst_i_ack", bus.i_ack, 0);
    chk("rst_d_ack", bus.d_ack, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_serial", bus.mem_serial, 0);
    mon_en = 1'b1;

    // Fetch load, then a store that must leave rdata alone.
    start_i(32'h40);
    wait_idle("fetch");
    chk("fetch_rdata", bus.rdata, 32'hDEADBEEF);
    start_d(1'b1, 32'h100, 32'h12345678);
    wait_idle("store");
    chk("store_rdata", bus.rdata, 32'hDEADBEEF);

    // Simultaneous requests.
    start_i(32'h200);
    start_d(1'b0, 32'h300, 32'h0);
    wait_idle("both");

    // Reset during the first BUSY cycle abandons the access.
    start_i(32'h44);
    tick(1'b0);
    reset = 1'b1; bus.i_req = 1'b0; ist = R_IDLE;
    tick(1'b0);
    reset = 1'b0;
    chk("midrst_mem_en", bus.mem_en, 0);
    chk("midrst_rdata", bus.rdata, 0);
    repeat (6) tick(1'b0);
    start_i(32'h48);
    wait_idle("after_rst");

    // Inputs change and request drops after grant.
    start_d(1'b0, 32'h500, 32'h0);
    tick(1'b0);
    bus.d_addr = 32'h999; bus.d_wdata = 32'hFFFF; bus.d_req = 1'b0; dst = R_DROP;
    wait_idle("drop");

    repeat (800) tick(1'b1);
    bus.i_req = bus.i_req; // no new requests from here on; held ones drain
    repeat (30) tick(1'b0);
    chk("drain_queue", q.size(), 0);
    chk("drain_idle", 128'(ist == R_IDLE && dst == R_IDLE), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
